// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one combinational ALU between two requesters through a registered
// req/ack handshake. A three-state controller (IDLE -> EXEC -> ACK) picks a
// winner, latches that requester's opcode and operands into the ALU input
// registers, and captures the ALU result and zero flag one cycle later. It
// then pulses the winner's acknowledge for one cycle.
//
// Build option: define ALU_ARB_FIXED_PRIO_EN so that requester 0 always wins
// a tie. The default build uses round-robin arbitration.
//
// Ports
//   clk, reset             clock; synchronous active-high reset
//   Req0_i / Req1_i        request from requester 0 / 1
//   Op*_i, A*_i, B*_i      opcode and operands from each requester
//   Ack0_o / Ack1_o        one-cycle pulse: result valid for that requester
//   Result_o, Zero_o       captured ALU result and zero flag (shared)
//   ALU_Operation_o        registered opcode to the ALU
//   ALU_A_o, ALU_B_o       registered operands to the ALU
//   ALU_Result_i           result returned by the ALU
//   ALU_Zero_i             zero flag returned by the ALU
module alu_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Req0_i,
  input  logic                  Req1_i,
  input  logic [OP_WIDTH-1:0]   Op0_i,
  input  logic [OP_WIDTH-1:0]   Op1_i,
  input  logic [DATA_WIDTH-1:0] A0_i,
  input  logic [DATA_WIDTH-1:0] B0_i,
  input  logic [DATA_WIDTH-1:0] A1_i,
  input  logic [DATA_WIDTH-1:0] B1_i,
  output logic                  Ack0_o,
  output logic                  Ack1_o,
  output logic [DATA_WIDTH-1:0] Result_o,
  output logic                  Zero_o,
  output logic [OP_WIDTH-1:0]   ALU_Operation_o,
  output logic [DATA_WIDTH-1:0] ALU_A_o,
  output logic [DATA_WIDTH-1:0] ALU_B_o,
  input  logic [DATA_WIDTH-1:0] ALU_Result_i,
  input  logic                  ALU_Zero_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   grant_q;
  logic   winner;
  logic   any_req;

`ifndef ALU_ARB_FIXED_PRIO_EN
  // Most recent winner. It resets to 1 so that requester 0 takes the first tie.
  logic last_q;
`endif

  assign any_req = Req0_i | Req1_i;

  // Winner index: 0 selects requester 0, 1 selects requester 1.
  always_comb begin
    winner = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    winner = ~Req0_i;
`else
    if (Req0_i && Req1_i) begin
      winner = ~last_q;
    end else begin
      winner = ~Req0_i;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = EXEC;
      EXEC:    state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      grant_q         <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_q          <= 1'b1;
`endif
      Ack0_o          <= 1'b0;
      Ack1_o          <= 1'b0;
      Result_o        <= '0;
      Zero_o          <= 1'b0;
      ALU_Operation_o <= '0;
      ALU_A_o         <= '0;
      ALU_B_o         <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          // Grant: latch the winner's operands. With no request, the ALU inputs hold.
          if (any_req) begin
            grant_q         <= winner;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_q          <= winner;
`endif
            ALU_Operation_o <= winner ? Op1_i : Op0_i;
            ALU_A_o         <= winner ? A1_i  : A0_i;
            ALU_B_o         <= winner ? B1_i  : B0_i;
          end
        end
        EXEC: begin
          // The ALU inputs were stable for a full cycle: capture the result and arm the ack.
          Result_o <= ALU_Result_i;
          Zero_o   <= ALU_Zero_i;
          Ack0_o   <= ~grant_q;
          Ack1_o   <= grant_q;
        end
        ACK: begin
          Ack0_o <= 1'b0;
          Ack1_o <= 1'b0;
        end
        default: begin
          Ack0_o <= 1'b0;
          Ack1_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter. It contains a behavioural ALU, a
// vector table, directed multi-cycle sequences, and a randomized run that is
// checked against a transaction-level reference model.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [3:0]  op0, op1;
  logic [31:0] a0, b0, a1, b1;
  logic        ack0, ack1;
  logic [31:0] result;
  logic        zero;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b;
  logic [31:0] alu_res;
  logic        alu_zero;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_WIDTH(32), .OP_WIDTH(4)) dut (
    .clk(clk), .reset(reset),
    .Req0_i(req0), .Req1_i(req1),
    .Op0_i(op0), .Op1_i(op1),
    .A0_i(a0), .B0_i(b0), .A1_i(a1), .B1_i(b1),
    .Ack0_o(ack0), .Ack1_o(ack1),
    .Result_o(result), .Zero_o(zero),
    .ALU_Operation_o(alu_op), .ALU_A_o(alu_a), .ALU_B_o(alu_b),
    .ALU_Result_i(alu_res), .ALU_Zero_i(alu_zero)
  );

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == 4'b0000) return a + b;
    if (op == 4'b0001) return a - b;
    return 32'd0;
  endfunction

  // Combinational ALU placed between the block's ALU outputs and ALU inputs
  always_comb begin
    alu_res  = ref_alu(alu_op, alu_a, alu_b);
    alu_zero = (alu_res == 32'd0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Ack log for one run_cycles call
  int          lw[$];
  int          li[$];
  logic [31:0] lr[$];
  logic        lz[$];

  // Runs ncyc cycles and logs each ack: requester, cycle index, result and zero.
  // A requester drops its Req at the edge that ends its Ack unless hold is set.
  task automatic run_cycles(input int ncyc, input bit hold0, input bit hold1);
    logic s0, s1;
    lw.delete(); li.delete(); lr.delete(); lz.delete();
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      s0 = ack0; s1 = ack1;
      if (s0 || s1) begin
        lw.push_back((s0 && s1) ? 2 : (s1 ? 1 : 0));
        li.push_back(i);
        lr.push_back(result);
        lz.push_back(zero);
      end
      @(posedge clk); #1;
      if (s0 && !hold0) req0 = 1'b0;
      if (s1 && !hold1) req1 = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic        who;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
  } vec_t;

  vec_t tbl[7];

  // Reference model state for the random run
  int          rem;
  bit          mlast, mwin;
  logic [31:0] mres;
  logic        mz;

  initial begin
    bit e0, e1, d0, d1;
    int exp_w;
    reset = 1'b1; req0 = 0; req1 = 0;
    op0 = 0; op1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;

    tbl[0] = '{1'b0, 4'b0000, 32'd7,  32'd5,  32'd12,         1'b0};
    tbl[1] = '{1'b1, 4'b0001, 32'd5,  32'd5,  32'd0,          1'b1};
    tbl[2] = '{1'b1, 4'b0001, 32'd3,  32'd10, 32'hFFFF_FFF9,  1'b0};
    tbl[3] = '{1'b0, 4'b1111, 32'd9,  32'd9,  32'd0,          1'b1};
    tbl[4] = '{1'b1, 4'b0000, 32'hFFFF_FFFF, 32'd1, 32'd0,    1'b1};
    tbl[5] = '{1'b0, 4'b0010, 32'd4,  32'd3,  32'd0,          1'b1};
    tbl[6] = '{1'b1, 4'b0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0};

    do_reset();
    @(negedge clk);
    check("rst_ack", {30'd0, ack0, ack1}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd0);
    check("rst_alu_op", {28'd0, alu_op}, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);

    // Simultaneous requests out of reset: requester 0 first, then requester 1
    @(posedge clk); #1;
    op0 = 4'b0000; a0 = 32'd1;  b0 = 32'd2;
    op1 = 4'b0001; a1 = 32'd10; b1 = 32'd3;
    req0 = 1'b1; req1 = 1'b1;
    run_cycles(8, 1'b0, 1'b0);
    check("sim_count", lw.size(), 2);
    if (lw.size() == 2) begin
      check("sim_first_who", lw[0], 0);
      check("sim_first_when", li[0], 3);
      check("sim_first_res", lr[0], 32'd3);
      check("sim_second_who", lw[1], 1);
      check("sim_second_when", li[1], 6);
      check("sim_second_res", lr[1], 32'd7);
    end

    // Both held for four rounds
    @(posedge clk); #1;
    req0 = 1'b1; req1 = 1'b1;
    run_cycles(12, 1'b1, 1'b1);
    req0 = 1'b0; req1 = 1'b0;
    check("alt_count", lw.size(), 4);
    for (int k = 0; k < lw.size(); k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_w = 0;
`else
      exp_w = k % 2;
`endif
      check($sformatf("alt_who_%0d", k), lw[k], exp_w);
      check($sformatf("alt_res_%0d", k), lr[k], (exp_w == 0) ? 32'd3 : 32'd7);
    end
    run_cycles(4, 1'b0, 1'b0);

    // Vector table: single-requester transactions
    foreach (tbl[k]) begin
      @(posedge clk); #1;
      if (tbl[k].who) begin
        op1 = tbl[k].op; a1 = tbl[k].a; b1 = tbl[k].b; req1 = 1'b1;
      end else begin
        op0 = tbl[k].op; a0 = tbl[k].a; b0 = tbl[k].b; req0 = 1'b1;
      end
      run_cycles(6, 1'b0, 1'b0);
      check($sformatf("vec%0d_count", k), lw.size(), 1);
      if (lw.size() == 1) begin
        check($sformatf("vec%0d_who", k), lw[0], {31'd0, tbl[k].who});
        check($sformatf("vec%0d_when", k), li[0], 3);
        check($sformatf("vec%0d_res", k), lr[0], tbl[k].res);
        check($sformatf("vec%0d_zero", k), {31'd0, lz[0]}, {31'd0, tbl[k].z});
      end
    end

    // Reset while in EXEC: no ack, nothing captured, everything back to reset values
    @(posedge clk); #1;
    op0 = 4'b0000; a0 = 32'd20; b0 = 32'd22; req0 = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; req0 = 1'b0;
    @(negedge clk);
    check("mid_rst_ack", {30'd0, ack0, ack1}, 32'd0);
    check("mid_rst_result", result, 32'd0);
    check("mid_rst_zero", {31'd0, zero}, 32'd0);
    check("mid_rst_alu_op", {28'd0, alu_op}, 32'd0);
    check("mid_rst_alu_a", alu_a, 32'd0);
    check("mid_rst_alu_b", alu_b, 32'd0);
    run_cycles(4, 1'b0, 1'b0);
    check("mid_rst_no_ack", lw.size(), 0);
    @(posedge clk); #1;
    op1 = 4'b0001; a1 = 32'd8; b1 = 32'd1;
    req0 = 1'b1; req1 = 1'b1;
    run_cycles(8, 1'b0, 1'b0);
    check("post_rst_count", lw.size(), 2);
    if (lw.size() == 2) begin
      check("post_rst_first", lw[0], 0);
      check("post_rst_res0", lr[0], 32'd42);
      check("post_rst_second", lw[1], 1);
      check("post_rst_res1", lr[1], 32'd7);
    end

    // Req0 held one cycle past its ack: a second grant with an identical result
    @(posedge clk); #1;
    op0 = 4'b0001; a0 = 32'd100; b0 = 32'd1; req0 = 1'b1;
    run_cycles(6, 1'b1, 1'b0);
    req0 = 1'b0;
    check("hold_count", lw.size(), 2);
    if (lw.size() == 2) begin
      check("hold_who0", lw[0], 0);
      check("hold_who1", lw[1], 0);
      check("hold_when1", li[1], 6);
      check("hold_res0", lr[0], 32'd99);
      check("hold_res1", lr[1], 32'd99);
    end
    run_cycles(4, 1'b0, 1'b0);
    check("hold_flush", lw.size(), 0);

    // Randomized run against a transaction-level model
    do_reset();
    rem = 0; mlast = 1'b1; mwin = 1'b0; mres = '0; mz = 1'b0;
    d0 = 0; d1 = 0;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk);
      e0 = 0; e1 = 0;
      if (rem == 2) begin
        rem = 1; e0 = (mwin == 1'b0); e1 = (mwin == 1'b1);
      end else if (rem == 1) begin
        rem = 0;
      end else if (req0 || req1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        mwin = req0 ? 1'b0 : 1'b1;
`else
        if (req0 && req1) mwin = ~mlast;
        else mwin = req0 ? 1'b0 : 1'b1;
`endif
        mlast = mwin;
        mres = mwin ? ref_alu(op1, a1, b1) : ref_alu(op0, a0, b0);
        mz = (mres == 32'd0);
        rem = 2;
      end
      #1;
      if (d0) begin
        req0 = 1'b0; d0 = 0;
      end else if (!req0 && ($urandom % 3 == 0)) begin
        case ($urandom % 4)
          0: op0 = 4'b0000;
          1: op0 = 4'b0001;
          default: op0 = 4'($urandom % 16);
        endcase
        a0 = $urandom; b0 = ($urandom % 4 == 0) ? a0 : $urandom;
        req0 = 1'b1;
      end
      if (d1) begin
        req1 = 1'b0; d1 = 0;
      end else if (!req1 && ($urandom % 3 == 0)) begin
        case ($urandom % 4)
          0: op1 = 4'b0000;
          1: op1 = 4'b0001;
          default: op1 = 4'($urandom % 16);
        endcase
        a1 = $urandom; b1 = ($urandom % 4 == 0) ? a1 : $urandom;
        req1 = 1'b1;
      end
      @(negedge clk);
      check("rnd_ack", {30'd0, ack0, ack1}, {30'd0, e0, e1});
      if (e0 || e1) begin
        check("rnd_res", result, mres);
        check("rnd_zero", {31'd0, zero}, {31'd0, mz});
      end
      if (ack0) d0 = 1;
      if (ack1) d1 = 1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
